neomatrix_frame_ctrl: RTL and testbench

NEOMATRIX_FRAME_CTRL -- requirements
Module: neomatrix_frame_ctrl

---
 rtl/neomatrix_pkg.sv | 25 ++
 rtl/neomatrix_scale.sv | 14 +
 rtl/neomatrix_frame_ctrl.sv | 148 ++++++++++++++
 tb/tb_neomatrix_frame_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neomatrix_pkg.sv
// Shared types and constants for the NeoPixel 8x8 frame controller.
package neomatrix_pkg;

   localparam int NUM_PIXELS_DEF   = 64;
   localparam int LATCH_CYCLES_DEF = 5000;

   // One GRB pixel: G in [23:16], R in [15:8], B in [7:0].
   typedef logic [23:0] pixel_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      SEND  = 3'd3,
      LATCH = 3'd4
   } state_t;

   // Scale one 8-bit channel by (brightness+1)/256 so that 255 is identity and 0 blanks.
   function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
      logic [16:0] w_prod;
      w_prod = {9'd0, c} * ({9'd0, b} + 17'd1);
      return 8'(w_prod >> 5'd8);
   endfunction

endpackage

// File: rtl/neomatrix_scale.sv
// Combinational per-channel brightness scaling of one GRB pixel.
module neomatrix_scale
   import neomatrix_pkg::*;
(
   input  pixel_t     i_pix,
   input  logic [7:0] i_brightness,
   output pixel_t     o_pix
);

   assign o_pix = {scale_chan(i_pix[23:16], i_brightness),
                   scale_chan(i_pix[15:8],  i_brightness),
                   scale_chan(i_pix[7:0],   i_brightness)};

endmodule

// File: rtl/neomatrix_frame_ctrl.sv
// Frame sequencer: fetches each pixel from the buffer, scales it, hands it to the
// bit serializer, then holds the line low for the latch time before the next frame.
module neomatrix_frame_ctrl
   import neomatrix_pkg::*;
#(
   parameter int NUM_PIXELS   = NUM_PIXELS_DEF,
   parameter int LATCH_CYCLES = LATCH_CYCLES_DEF
)(
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic        start,
   input  logic        auto_en,
   input  logic [7:0]  brightness,
   output logic        mem_en,
   output logic [5:0]  mem_addr,
   input  logic [23:0] mem_rdata,
   output logic [23:0] pix_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_cnt
);

   localparam logic [5:0]     LAST_IDX   = 6'(NUM_PIXELS - 1);
   localparam int             LCW        = $clog2(LATCH_CYCLES + 1);
   localparam logic [LCW-1:0] LATCH_LAST = LCW'(LATCH_CYCLES - 1);

   state_t         r_state;
   state_t         w_state_nxt;
   logic [5:0]     r_index;
   logic [5:0]     w_index_nxt;
   logic [LCW-1:0] r_lat_cnt;
   logic [LCW-1:0] w_lat_cnt_nxt;
   logic           w_done_nxt;
   pixel_t         w_scaled;

   logic           r_mem_en;
   logic [5:0]     r_mem_addr;
   pixel_t         r_pix_data;
   logic           r_pix_valid;
   logic           r_busy;
   logic           r_frame_done;
   logic [15:0]    r_frame_cnt;

   neomatrix_scale u_scale (
      .i_pix        (mem_rdata),
      .i_brightness (brightness),
      .o_pix        (w_scaled)
   );

   // Next-state, pixel index and latch-timer decisions.
   always_comb begin
      w_state_nxt   = r_state;
      w_index_nxt   = r_index;
      w_lat_cnt_nxt = r_lat_cnt;
      w_done_nxt    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start || auto_en) begin
               w_state_nxt = FETCH;
               w_index_nxt = 6'd0;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         FETCH: begin
            w_state_nxt = LOAD;
         end
         LOAD: begin
            w_state_nxt = SEND;
         end
         SEND: begin
            if (r_pix_valid && pix_ready) begin
               if (r_index == LAST_IDX) begin
                  w_state_nxt   = LATCH;
                  w_lat_cnt_nxt = '0;
               end else begin
                  w_state_nxt = FETCH;
                  w_index_nxt = r_index + 6'd1;
               end
            end else begin
               w_state_nxt = SEND;
            end
         end
         LATCH: begin
            // The frame_done cycle is the last LATCH cycle; leave on the edge after it.
            if (r_frame_done) begin
               if (auto_en) begin
                  w_state_nxt = FETCH;
                  w_index_nxt = 6'd0;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else if (r_lat_cnt == LATCH_LAST) begin
               w_done_nxt = 1'b1;
            end else begin
               w_lat_cnt_nxt = r_lat_cnt + LCW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_index_nxt = 6'd0;
         end
      endcase
   end

   // State register plus registered outputs decoded from the next state.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state      <= IDLE;
         r_index      <= 6'd0;
         r_lat_cnt    <= '0;
         r_mem_en     <= 1'b0;
         r_mem_addr   <= 6'd0;
         r_pix_data   <= 24'd0;
         r_pix_valid  <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= 16'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_index      <= w_index_nxt;
         r_lat_cnt    <= w_lat_cnt_nxt;
         r_mem_en     <= (w_state_nxt == FETCH);
         r_mem_addr   <= w_index_nxt;
         r_pix_valid  <= (w_state_nxt == SEND);
         r_busy       <= (w_state_nxt != IDLE);
         r_frame_done <= w_done_nxt;
         // Brightness is captured with the pixel, so a mid-frame change hits the next pixel.
         if (r_state == LOAD) begin
            r_pix_data <= w_scaled;
         end
         if (w_done_nxt) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign mem_en     = r_mem_en;
   assign mem_addr   = r_mem_addr;
   assign pix_data   = r_pix_data;
   assign pix_valid  = r_pix_valid;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_neomatrix_frame_ctrl.sv
// Self-checking bench for neomatrix_frame_ctrl: a timeline model checks every cycle,
// directed scenarios add literal expectations.
`timescale 1ns/1ps
module tb_neomatrix_frame_ctrl;

   localparam int NPIX  = 64;
   localparam int LATCH = 5000;

   logic        ACLK = 1'b0;
   logic        ARESET, start, auto_en, pix_ready;
   logic [7:0]  brightness;
   logic        mem_en, pix_valid, busy, frame_done;
   logic [5:0]  mem_addr;
   logic [23:0] mem_rdata = 24'd0;
   logic [23:0] pix_data;
   logic [15:0] frame_cnt;

   logic [23:0] mem [0:63];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always #5 ACLK = ~ACLK;

   neomatrix_frame_ctrl dut (
      .ACLK       (ACLK),
      .ARESET     (ARESET),
      .start      (start),
      .auto_en    (auto_en),
      .brightness (brightness),
      .mem_en     (mem_en),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt)
   );

   // Pixel buffer with one-cycle read latency.
   always @(posedge ACLK) begin
      if (mem_en) mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [23:0] model_scale(input logic [23:0] p, input int b);
      int g, r, bl;
      g  = (int'(p[23:16]) * (b + 1)) / 256;
      r  = (int'(p[15:8])  * (b + 1)) / 256;
      bl = (int'(p[7:0])   * (b + 1)) / 256;
      return {g[7:0], r[7:0], bl[7:0]};
   endfunction

   // Timeline model state
   int          next_fetch = -1;
   int          valid_from = -1;
   int          done_at    = -1;
   int          m_idx      = 0;
   int          m_frames   = 0;
   bit          m_active   = 1'b0;
   bit          rst_d      = 1'b1;
   int          bright_prev = 255;
   logic [23:0] exp_data   = 24'd0;
   int          hs_frame   = 0;
   int          last_frame_hs = 0;
   logic [23:0] hs_data [0:63];

   initial begin : compare
      bit exp_memen, exp_valid, exp_done, was_active;
      forever begin
         @(negedge ACLK);
         cyc++;
         if (rst_d) begin
            check("rst_mem_en", mem_en, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_pix_data", pix_data, 0);
            check("rst_pix_valid", pix_valid, 0);
            check("rst_frame_done", frame_done, 0);
            check("rst_frame_cnt", frame_cnt, 0);
            check("rst_busy", busy, 0);
            m_active = 1'b0; next_fetch = -1; valid_from = -1; done_at = -1;
            m_idx = 0; m_frames = 0; hs_frame = 0;
            was_active = 1'b0;
         end else begin
            exp_memen = (cyc == next_fetch);
            exp_valid = (valid_from >= 0) && (cyc >= valid_from);
            exp_done  = (cyc == done_at);
            check("mem_en", mem_en, exp_memen);
            if (exp_memen) check("mem_addr", mem_addr, m_idx);
            check("pix_valid", pix_valid, exp_valid);
            if (exp_valid) begin
               if (cyc == valid_from) exp_data = model_scale(mem[m_idx], bright_prev);
               check("pix_data", pix_data, exp_data);
            end
            check("frame_done", frame_done, exp_done);
            if (exp_done) begin
               m_frames = (m_frames + 1) % 65536;
               last_frame_hs = hs_frame;
               hs_frame = 0;
            end
            check("frame_cnt", frame_cnt, m_frames);
            check("busy", busy, m_active);
            was_active = m_active;
            if (exp_valid && pix_ready) begin
               hs_data[m_idx] = pix_data;
               hs_frame++;
               valid_from = -1;
               if (m_idx == NPIX - 1) begin
                  done_at = cyc + LATCH + 1;
                  m_idx = 0;
               end else begin
                  m_idx++;
                  next_fetch = cyc + 1;
               end
            end
            if (exp_memen) valid_from = cyc + 2;
            if (exp_done) begin
               if (auto_en) next_fetch = cyc + 1;
               else m_active = 1'b0;
            end
         end
         if (!was_active && !ARESET && (start || auto_en)) begin
            m_active = 1'b1;
            m_idx = 0;
            next_fetch = cyc + 1;
         end
         bright_prev = brightness;
         rst_d = ARESET;
      end
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (frame_done !== 1'b1 && n < 6000) begin tick(); n++; end
      if (n >= 6000) check({name, "_timeout"}, 0, 1);
      else begin @(negedge ACLK); #1; end
   endtask

   task automatic wait_pix(input logic [23:0] d, input string name);
      int n = 0;
      while (!(pix_valid === 1'b1 && pix_data === d) && n < 400) begin tick(); n++; end
      if (n >= 400) check({name, "_timeout"}, 0, 1);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      do begin tick(); n++; end while (pix_valid !== 1'b1 && n < 400);
      if (n >= 400) check({name, "_timeout"}, 0, 1);
   endtask

   task automatic pulse_start();
      tick(); start = 1'b1;
      tick(); start = 1'b0;
   endtask

   initial begin : stim
      int n;
      ARESET = 1'b1; start = 1'b0; auto_en = 1'b0; brightness = 8'd255; pix_ready = 1'b1;
      for (int i = 0; i < 64; i++) mem[i] = 24'(i) * 24'h010101;
      repeat (3) tick();
      ARESET = 1'b0;
      tick();
      check("init_frame_cnt", frame_cnt, 0);
      check("init_busy", busy, 0);

      // Single frame at full brightness
      pulse_start();
      check("lat_mem_en", mem_en, 1);
      check("lat_mem_addr", mem_addr, 0);
      tick();
      check("lat_load_no_valid", pix_valid, 0);
      tick();
      check("lat_valid", pix_valid, 1);
      check("lat_pix0", pix_data, 24'h000000);
      wait_done("t1");
      check("t1_handshakes", last_frame_hs, 64);
      check("t1_pix10", hs_data[10], 24'h0A0A0A);
      check("t1_pix63", hs_data[63], 24'h3F3F3F);
      check("t1_frame_cnt", frame_cnt, 1);
      tick();
      check("t1_idle_busy", busy, 0);

      // Backpressure on pixel 5 for 10 cycles
      pulse_start();
      wait_pix(24'h050505, "t2_pix5");
      pix_ready = 1'b0;
      repeat (10) begin
         tick();
         check("t2_stall_valid", pix_valid, 1);
         check("t2_stall_data", pix_data, 24'h050505);
      end
      pix_ready = 1'b1;
      n = 0;
      do begin tick(); n++; end while (pix_valid !== 1'b1 && n < 10);
      check("t2_gap", n, 3);
      check("t2_pix6", pix_data, 24'h060606);
      wait_done("t2");
      check("t2_frame_cnt", frame_cnt, 2);

      // Brightness: G=0xFF*128>>8=0x7F, R=0x80*128>>8=0x40, B=0
      mem[0] = 24'hFF8000;
      mem[1] = 24'hFF8000;
      tick(); brightness = 8'd127; start = 1'b1;
      tick(); start = 1'b0;
      wait_valid("t3_p0");
      check("t3_bright127", pix_data, 24'h7F4000);
      brightness = 8'd0;
      wait_valid("t3_p1");
      check("t3_bright0", pix_data, 24'h000000);
      brightness = 8'd255;
      wait_done("t3");
      check("t3_frame_cnt", frame_cnt, 3);
      mem[0] = 24'h000000;
      mem[1] = 24'h010101;

      // Continuous refresh, dropped during the third frame
      tick(); auto_en = 1'b1;
      wait_done("t4_f1");
      tick();
      check("t4_back2back_en", mem_en, 1);
      check("t4_back2back_addr", mem_addr, 0);
      wait_done("t4_f2");
      tick();
      check("t4_back2back_en2", mem_en, 1);
      wait_valid("t4_f3");
      auto_en = 1'b0;
      wait_done("t4_f3");
      check("t4_frame_cnt", frame_cnt, 6);
      tick();
      check("t4_idle_busy", busy, 0);
      check("t4_idle_mem_en", mem_en, 0);

      // start while busy is ignored
      pulse_start();
      wait_pix(24'h1E1E1E, "t5_pix30");
      start = 1'b1;
      tick(); start = 1'b0;
      wait_done("t5");
      check("t5_handshakes", last_frame_hs, 64);
      check("t5_frame_cnt", frame_cnt, 7);
      repeat (3) tick();
      check("t5_not_queued", busy, 0);

      // Reset in the middle of the frame
      pulse_start();
      wait_pix(24'h282828, "t6_pix40");
      ARESET = 1'b1;
      tick();
      check("t6_valid", pix_valid, 0);
      check("t6_mem_en", mem_en, 0);
      check("t6_pix_data", pix_data, 0);
      check("t6_frame_cnt", frame_cnt, 0);
      check("t6_busy", busy, 0);
      ARESET = 1'b0;
      repeat (3) tick();
      check("t6_no_restart", busy, 0);
      pulse_start();
      check("t6_restart_en", mem_en, 1);
      check("t6_restart_addr", mem_addr, 0);
      wait_done("t6");
      check("t6_frame_cnt_after", frame_cnt, 1);

      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
